// File: rtl/hypercorex_inst_loop_ctrl.sv
// Instruction-address sequencer for Hypercorex: steps the program counter from 0 to the
// programmed end address. Up to NumLoops nested hardware loops are resolved without bubbles.
module hypercorex_inst_loop_ctrl #(
    parameter int unsigned InstMemDepth = 1024,
    parameter int unsigned NumLoops     = 3,
    parameter int unsigned LoopCntWidth = 10,
    parameter int unsigned AddrWidth    = $clog2(InstMemDepth),
    parameter int unsigned LoopSelWidth = $clog2(NumLoops + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic                             stop_i,
    input  logic [LoopSelWidth-1:0]          num_loops_i,
    input  logic [AddrWidth-1:0]             prog_end_addr_i,
    input  logic [NumLoops*AddrWidth-1:0]    loop_jump_addr_i,
    input  logic [NumLoops*AddrWidth-1:0]    loop_end_addr_i,
    input  logic [NumLoops*LoopCntWidth-1:0] loop_count_i,
    output logic [AddrWidth-1:0]             inst_addr_o,
    output logic                             inst_valid_o,
    input  logic                             inst_ready_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [NumLoops*LoopCntWidth-1:0] loop_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [AddrWidth-1:0]   pc_reg;
    logic                   done_reg;

    logic                   running;
    logic                   accept;
    logic                   any_jump;
    logic                   at_prog_end;
    logic                   finish;
    logic [AddrWidth-1:0]   pc_incr;
    logic [AddrWidth-1:0]   pc_next;
    logic [AddrWidth-1:0]   jump_target;

    logic [NumLoops-1:0]    slot_at_end;
    logic [NumLoops-1:0]    slot_can_jump;
    logic [NumLoops-1:0]    jump_sel;
    logic [NumLoops-1:0]    clear_sel;
    logic [NumLoops:0]      lower_jump;
    logic [NumLoops-1:0][AddrWidth-1:0] jump_masked;

    assign running = (state_reg == RUN);
    assign accept  = running && inst_ready_i;

    // lower_jump[i] is set when some slot below i can take its jump; the innermost wins.
    always_comb begin
        lower_jump = '0;
        for (int i = 0; i < int'(NumLoops); i++) begin
            lower_jump[i+1] = lower_jump[i] | slot_can_jump[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < int'(NumLoops); gi++) begin : g_slot
            logic [AddrWidth-1:0]    jump_addr;
            logic [AddrWidth-1:0]    end_addr;
            logic [LoopCntWidth-1:0] count_cfg;
            logic [LoopCntWidth-1:0] cnt_last;
            logic [LoopCntWidth-1:0] cnt_reg;
            logic                    slot_active;

            assign jump_addr   = loop_jump_addr_i[gi*AddrWidth +: AddrWidth];
            assign end_addr    = loop_end_addr_i[gi*AddrWidth +: AddrWidth];
            assign count_cfg   = loop_count_i[gi*LoopCntWidth +: LoopCntWidth];
            // A programmed count of 0 behaves like 1: the body runs once and never jumps back.
            assign cnt_last    = (count_cfg == '0) ? '0 : count_cfg - LoopCntWidth'(1);
            assign slot_active = (LoopSelWidth'(gi) < num_loops_i);

            assign slot_at_end[gi]   = slot_active && (pc_reg == end_addr);
            assign slot_can_jump[gi] = slot_at_end[gi] && (cnt_reg < cnt_last);
            assign jump_sel[gi]      = slot_can_jump[gi] && !lower_jump[gi];
            // Slots that end here but lie below the jumping slot (or all, if none jumps) restart.
            assign clear_sel[gi]     = slot_at_end[gi] && !lower_jump[gi+1];
            assign jump_masked[gi]   = jump_sel[gi] ? jump_addr : '0;

            assign loop_cnt_o[gi*LoopCntWidth +: LoopCntWidth] = cnt_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg <= '0;
                end else if (!running) begin
                    if (start_i) begin
                        cnt_reg <= '0;
                    end
                end else if (stop_i) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    if (finish || clear_sel[gi]) begin
                        cnt_reg <= '0;
                    end else if (jump_sel[gi]) begin
                        cnt_reg <= cnt_reg + LoopCntWidth'(1);
                    end
                end
            end
        end
    endgenerate

    // jump_sel is one-hot or empty, so an OR of the masked targets selects the winner.
    always_comb begin
        jump_target = '0;
        for (int i = 0; i < int'(NumLoops); i++) begin
            jump_target = jump_target | jump_masked[i];
        end
    end

    assign any_jump    = lower_jump[NumLoops];
    assign at_prog_end = (pc_reg == prog_end_addr_i);
    assign finish      = !any_jump && at_prog_end;
    assign pc_incr     = (pc_reg == AddrWidth'(InstMemDepth - 1)) ? '0 : pc_reg + AddrWidth'(1);
    assign pc_next     = any_jump ? jump_target : pc_incr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_reg <= RUN;
                        pc_reg    <= '0;
                    end
                end
                RUN: begin
                    // Stop wins over a same-cycle accept: the handshake completes, pc stays put.
                    if (stop_i) begin
                        state_reg <= IDLE;
                    end else if (inst_ready_i) begin
                        if (finish) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            pc_reg <= pc_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign inst_addr_o  = pc_reg;
    assign inst_valid_o = running;
    assign busy_o       = running;
    assign done_o       = done_reg;

endmodule

// File: tb/tb_hypercorex_inst_loop_ctrl.sv
// Directed bench for hypercorex_inst_loop_ctrl: a spec-level sequencing model checked every
// cycle, plus literal address/counter traces for each directed program.
module tb_hypercorex_inst_loop_ctrl;
    localparam int AW = 3;
    localparam int NL = 3;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic ready = 1'b0;
    logic [1:0]    num_loops = '0;
    logic [AW-1:0] prog_end = '0;
    logic [AW-1:0] jmp [NL];
    logic [AW-1:0] endv [NL];
    logic [CW-1:0] cnt_cfg [NL];

    logic [NL*AW-1:0] loop_jump_addr;
    logic [NL*AW-1:0] loop_end_addr;
    logic [NL*CW-1:0] loop_count;
    logic [AW-1:0]    inst_addr;
    logic             inst_valid;
    logic             busy;
    logic             done;
    logic [NL*CW-1:0] loop_cnt;

    assign loop_jump_addr = {jmp[2], jmp[1], jmp[0]};
    assign loop_end_addr  = {endv[2], endv[1], endv[0]};
    assign loop_count     = {cnt_cfg[2], cnt_cfg[1], cnt_cfg[0]};

    hypercorex_inst_loop_ctrl #(
        .InstMemDepth (8),
        .NumLoops     (NL),
        .LoopCntWidth (CW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .stop_i           (stop),
        .num_loops_i      (num_loops),
        .prog_end_addr_i  (prog_end),
        .loop_jump_addr_i (loop_jump_addr),
        .loop_end_addr_i  (loop_end_addr),
        .loop_count_i     (loop_count),
        .inst_addr_o      (inst_addr),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (ready),
        .busy_o           (busy),
        .done_o           (done),
        .loop_cnt_o       (loop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int tr_addr[$];
    int tr_cnt0[$];
    int exp_addr[$];
    int exp_cnt0[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program state as plain integers.
    bit m_run = 1'b0;
    bit m_done = 1'b0;
    int m_pc = 0;
    int m_cnt[NL];

    task automatic model_accept();
        int a;
        int k;
        int lim;
        a = m_pc;
        k = -1;
        for (int i = 0; i < int'(num_loops); i++) begin
            lim = (int'(cnt_cfg[i]) == 0) ? 1 : int'(cnt_cfg[i]);
            if (k < 0 && a == int'(endv[i]) && m_cnt[i] < lim - 1) k = i;
        end
        if (k >= 0) begin
            m_pc = int'(jmp[k]);
            m_cnt[k] = m_cnt[k] + 1;
            for (int j = 0; j < k; j++) if (int'(endv[j]) == a) m_cnt[j] = 0;
        end else begin
            for (int j = 0; j < int'(num_loops); j++) if (int'(endv[j]) == a) m_cnt[j] = 0;
            if (a == int'(prog_end)) begin
                m_run = 1'b0;
                m_done = 1'b1;
                for (int j = 0; j < NL; j++) m_cnt[j] = 0;
            end else begin
                m_pc = (a + 1) % 8;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0;
            m_done = 1'b0;
            m_pc = 0;
            for (int j = 0; j < NL; j++) m_cnt[j] = 0;
        end else begin
            m_done = 1'b0;
            if (!m_run) begin
                if (start) begin
                    m_run = 1'b1;
                    m_pc = 0;
                    for (int j = 0; j < NL; j++) m_cnt[j] = 0;
                end
            end else if (stop) begin
                m_run = 1'b0;
                for (int j = 0; j < NL; j++) m_cnt[j] = 0;
            end else if (ready) begin
                model_accept();
            end
        end
    end

    // Compare process: every cycle out of reset, mid-way between active edges.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", inst_valid, m_run);
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("loop_cnt", loop_cnt, {CW'(m_cnt[2]), CW'(m_cnt[1]), CW'(m_cnt[0])});
            if (m_run) chk("addr", inst_addr, m_pc);
            if (inst_valid && ready) begin
                tr_addr.push_back(int'(inst_addr));
                tr_cnt0.push_back(int'(loop_cnt[CW-1:0]));
            end
            if (done) done_seen++;
        end
    end

    task automatic set_cfg(input int n, input int pe, input int j0, input int e0, input int c0,
                           input int j1, input int e1, input int c1);
        num_loops  = 2'(n);
        prog_end   = AW'(pe);
        jmp[0]     = AW'(j0);
        endv[0]    = AW'(e0);
        cnt_cfg[0] = CW'(c0);
        jmp[1]     = AW'(j1);
        endv[1]    = AW'(e1);
        cnt_cfg[1] = CW'(c1);
        jmp[2]     = '0;
        endv[2]    = '0;
        cnt_cfg[2] = '0;
    endtask

    task automatic check_trace(input string name);
        int n;
        chk({name, " trace_len"}, tr_addr.size(), exp_addr.size());
        n = (tr_addr.size() < exp_addr.size()) ? tr_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s addr[%0d]", name, i), tr_addr[i], exp_addr[i]);
    endtask

    task automatic pulse_start();
        tr_addr.delete();
        tr_cnt0.delete();
        done_seen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready follows 1,0,0,1 repeating.
    task automatic run_prog(input string name, input int mode);
        bit finished;
        finished = 1'b0;
        pulse_start();
        for (int c = 0; c < 100 && !finished; c++) begin
            ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            @(posedge clk); #1;
            if (done) finished = 1'b1;
        end
        if (!finished) chk({name, " completion_timeout"}, 0, 1);
        ready = 1'b0;
        @(posedge clk); #1;
        chk({name, " done_count"}, done_seen, 1);
        chk({name, " busy_after"}, busy, 0);
        check_trace(name);
        printf_line(name);
    endtask

    task automatic printf_line(input string name);
        $display("%s: %0d addresses, errors so far %0d", name, tr_addr.size(), errors);
    endtask

    initial begin
        bit hit;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", inst_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset addr", inst_addr, 0);
        chk("reset loop_cnt", loop_cnt, 0);
        rst_n = 1'b1;

        set_cfg(0, 4, 0, 0, 0, 0, 0, 0);
        exp_addr = '{0, 1, 2, 3, 4};
        run_prog("no_loops", 0);

        set_cfg(1, 3, 1, 2, 3, 0, 0, 0);
        exp_addr = '{0, 1, 2, 1, 2, 1, 2, 3};
        run_prog("single_loop", 0);
        exp_cnt0 = '{0, 0, 0, 1, 1, 2, 2, 0};
        chk("single_loop cnt_len", tr_cnt0.size(), exp_cnt0.size());
        for (int i = 0; i < tr_cnt0.size() && i < exp_cnt0.size(); i++)
            chk($sformatf("single_loop cnt0[%0d]", i), tr_cnt0[i], exp_cnt0[i]);

        set_cfg(2, 3, 2, 3, 2, 1, 3, 2);
        exp_addr = '{0, 1, 2, 3, 2, 3, 1, 2, 3, 2, 3};
        run_prog("nested_shared_end", 0);

        set_cfg(1, 3, 1, 2, 3, 0, 0, 0);
        exp_addr = '{0, 1, 2, 1, 2, 1, 2, 3};
        run_prog("backpressure", 1);

        set_cfg(1, 3, 1, 2, 0, 0, 0, 0);
        exp_addr = '{0, 1, 2, 3};
        run_prog("count_zero", 0);

        set_cfg(0, 3, 0, 0, 0, 1, 2, 3);
        exp_addr = '{0, 1, 2, 3};
        run_prog("inactive_slot", 0);

        set_cfg(1, 1, 2, 1, 2, 0, 0, 0);
        exp_addr = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        run_prog("wrap", 0);

        // Stop on the second visit to address 2 of the single-loop program.
        set_cfg(1, 3, 1, 2, 3, 0, 0, 0);
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            ready = 1'b1;
            if (inst_valid && inst_addr == 3'd2 && loop_cnt[CW-1:0] == 10'd1) begin
                stop = 1'b1;
                hit = 1'b1;
            end
            @(posedge clk); #1;
            stop = 1'b0;
        end
        if (!hit) chk("stop reach_point_timeout", 0, 1);
        chk("stop busy_next", busy, 0);
        chk("stop valid_next", inst_valid, 0);
        chk("stop loop_cnt", loop_cnt, 0);
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stop done_count", done_seen, 0);
        exp_addr = '{0, 1, 2, 1, 2};
        check_trace("stop");
        printf_line("stop");

        // Asynchronous reset mid-run, after the loop counter has moved.
        pulse_start();
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset loop_cnt", loop_cnt, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset valid", inst_valid, 0);
        chk("async_reset busy", busy, 0);
        chk("async_reset done", done, 0);
        chk("async_reset addr", inst_addr, 0);
        chk("async_reset loop_cnt", loop_cnt, 0);
        ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        printf_line("async_reset");

        set_cfg(0, 4, 0, 0, 0, 0, 0, 0);
        exp_addr = '{0, 1, 2, 3, 4};
        run_prog("restart", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
